// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline flush / redirect controller.
package pipe_flush_ctrl_pkg;

    // Redirect controller states.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRedirect = 2'd1,
        StHold     = 2'd2
    } state_e;

    // Request source indices into the req_* vectors.
    localparam int unsigned SRC_JUMP   = 0;
    localparam int unsigned SRC_BRANCH = 1;
    localparam int unsigned SRC_JR     = 2;
    localparam int unsigned SRC_EXC    = 3;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned HOLD_W  = 4;

    // Width of an index over n items; never narrower than one bit.
    function automatic int unsigned stg_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Request / redirect bundle between the pipeline control logic and the flush controller.
interface pipe_flush_ctrl_if
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned ADDR_W     = 32
);
    localparam int unsigned STG_W = stg_w(NUM_STAGES);

    logic [NUM_SRC-1:0]        req_valid;
    logic [NUM_SRC*STG_W-1:0]  req_stage;
    logic [NUM_SRC*ADDR_W-1:0] req_target;
    logic [NUM_STAGES-1:0]     flush_vec;
    logic                      redirect_valid;
    logic [ADDR_W-1:0]         redirect_target;
    logic                      redirect_ready;
    logic                      fetch_stall;
    logic [COUNT_W-1:0]        flush_count;

    // Pipeline side: raises requests, accepts the redirect.
    modport master (
        output req_valid,
        output req_stage,
        output req_target,
        output redirect_ready,
        input  flush_vec,
        input  redirect_valid,
        input  redirect_target,
        input  fetch_stall,
        input  flush_count
    );

    // Controller side.
    modport slave (
        input  req_valid,
        input  req_stage,
        input  req_target,
        input  redirect_ready,
        output flush_vec,
        output redirect_valid,
        output redirect_target,
        output fetch_stall,
        output flush_count
    );

endinterface

// File: rtl/pipe_flush_ctrl_arbiter.sv
// Combinational arbiter: picks the youngest-resolving (highest stage) request,
// lowest source index on a tie, and produces the stage flush mask for it.
module flush_arbiter
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned NUM_STAGES = 5,
    localparam int unsigned STG_W     = stg_w(NUM_STAGES),
    localparam int unsigned IDX_W     = stg_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]       req_valid,
    input  logic [NUM_SRC*STG_W-1:0] req_stage,
    output logic                     win_valid,
    output logic [IDX_W-1:0]         win_idx,
    output logic [NUM_STAGES-1:0]    flush_bits
);

    logic [STG_W-1:0] win_stage;

    // Scan sources in index order; only a strictly higher stage displaces the
    // current pick, so ties keep the lowest index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_stage = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (req_valid[i] &&
                (!win_valid || (req_stage[i*STG_W +: STG_W] > win_stage))) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_stage = req_stage[i*STG_W +: STG_W];
            end
        end
    end

    // Everything younger than the resolving stage is wrong-path.
    always_comb begin
        flush_bits = '0;
        for (int j = 0; j < int'(NUM_STAGES); j++) begin
            flush_bits[j] = win_valid && (int'(win_stage) > j);
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush and fetch-redirect controller. Arbitrates control-transfer
// requests, flushes wrong-path stages, offers the new PC to fetch and stalls
// fetch for a programmable number of cycles after the redirect is taken.
module pipe_flush_ctrl
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_flush_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = stg_w(NUM_SRC);
    localparam logic [HOLD_W-1:0] HOLD_INIT =
        (FLUSH_HOLD == 0) ? '0 : HOLD_W'(FLUSH_HOLD - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_STAGES-1:0] arb_flush;
    logic [ADDR_W-1:0]     win_target;
    logic [NUM_STAGES-1:0] flush_vec_c;

    flush_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES)
    ) u_arbiter (
        .req_valid  (bus.req_valid),
        .req_stage  (bus.req_stage),
        .win_valid  (win_valid),
        .win_idx    (win_idx),
        .flush_bits (arb_flush)
    );

    // Select the winning source's redirect address.
    always_comb begin
        win_target = bus.req_target[int'(win_idx)*ADDR_W +: ADDR_W];
    end

    // Next-state logic; a new winner overrides whatever the FSM was doing,
    // including an acceptance in the same cycle.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        target_d = target_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
            end
            StRedirect: begin
                if (bus.redirect_ready) begin
                    if (FLUSH_HOLD == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (win_valid) begin
            state_d  = StRedirect;
            target_d = win_target;
            if (count_q != {COUNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State, hold counter, redirect target and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    // Flush mask: arbitration bits, IF held flushed while redirecting, and
    // every stage flushed while reset is asserted (independent of the clock).
    always_comb begin
        flush_vec_c = arb_flush;
        if (state_q != StIdle) begin
            flush_vec_c[0] = 1'b1;
        end
        if (!rst_n) begin
            flush_vec_c = '1;
        end
    end

    assign bus.flush_vec       = flush_vec_c;
    assign bus.redirect_valid  = (state_q == StRedirect);
    assign bus.redirect_target = target_q;
    assign bus.fetch_stall     = (state_q != StIdle);
    assign bus.flush_count     = count_q;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Self-checking bench for pipe_flush_ctrl: three instances (FLUSH_HOLD 0, 1, 4)
// share one stimulus stream and are compared every cycle against a
// transaction-level model; directed scenarios pin the model with literals.
module tb_pipe_flush_ctrl;
    import pipe_flush_ctrl_pkg::*;

    localparam int NS = 5;
    localparam int NQ = 4;
    localparam int AW = 32;
    localparam int SW = 3;
    localparam int ND = 3;

    logic clk;
    logic rst_n;
    logic [NQ-1:0]    rv_in;
    logic [NQ*SW-1:0] stg_in;
    logic [NQ*AW-1:0] tgt_in;
    logic             rdy;

    int checks;
    int failures;

    int hold_of[ND] = '{0, 1, 4};

    // Model: is a redirect being offered, how many stall cycles remain after
    // acceptance, last target, and the request count.
    bit          m_off[ND];
    int          m_stall[ND];
    logic [31:0] m_tgt[ND];
    int          m_cnt[ND];

    logic [NS-1:0] o_fv[ND];
    logic          o_rv[ND];
    logic [AW-1:0] o_rt[ND];
    logic          o_fs[ND];
    logic [15:0]   o_fc[ND];

    pipe_flush_ctrl_if #(.NUM_SRC(NQ), .NUM_STAGES(NS), .ADDR_W(AW)) b0 ();
    pipe_flush_ctrl_if #(.NUM_SRC(NQ), .NUM_STAGES(NS), .ADDR_W(AW)) b1 ();
    pipe_flush_ctrl_if #(.NUM_SRC(NQ), .NUM_STAGES(NS), .ADDR_W(AW)) b2 ();

    assign b0.req_valid = rv_in;  assign b0.req_stage = stg_in;
    assign b0.req_target = tgt_in; assign b0.redirect_ready = rdy;
    assign b1.req_valid = rv_in;  assign b1.req_stage = stg_in;
    assign b1.req_target = tgt_in; assign b1.redirect_ready = rdy;
    assign b2.req_valid = rv_in;  assign b2.req_stage = stg_in;
    assign b2.req_target = tgt_in; assign b2.redirect_ready = rdy;

    assign o_fv[0] = b0.flush_vec; assign o_rv[0] = b0.redirect_valid;
    assign o_rt[0] = b0.redirect_target; assign o_fs[0] = b0.fetch_stall;
    assign o_fc[0] = b0.flush_count;
    assign o_fv[1] = b1.flush_vec; assign o_rv[1] = b1.redirect_valid;
    assign o_rt[1] = b1.redirect_target; assign o_fs[1] = b1.fetch_stall;
    assign o_fc[1] = b1.flush_count;
    assign o_fv[2] = b2.flush_vec; assign o_rv[2] = b2.redirect_valid;
    assign o_rt[2] = b2.redirect_target; assign o_fs[2] = b2.fetch_stall;
    assign o_fc[2] = b2.flush_count;

    pipe_flush_ctrl #(.NUM_STAGES(NS), .NUM_SRC(NQ), .ADDR_W(AW), .FLUSH_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    pipe_flush_ctrl #(.NUM_STAGES(NS), .NUM_SRC(NQ), .ADDR_W(AW), .FLUSH_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    pipe_flush_ctrl #(.NUM_STAGES(NS), .NUM_SRC(NQ), .ADDR_W(AW), .FLUSH_HOLD(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        rv_in = '0;
        stg_in = '0;
        tgt_in = '0;
    endtask

    task automatic set_req(input int src, input int stage, input logic [31:0] tgt);
        rv_in[src] = 1'b1;
        stg_in[src*SW +: SW] = SW'(stage);
        tgt_in[src*AW +: AW] = tgt;
    endtask

    // Compare every instance against the model at the falling edge, advance
    // the model with this cycle's inputs, then return just after the rising edge.
    task automatic tick();
        bit          win;
        int          ws;
        int          s;
        logic [31:0] wt;
        logic [NS-1:0] mask;
        logic [NS-1:0] exp_fv;
        bit          stall;
        @(negedge clk);
        win = 0; ws = 0; wt = '0;
        for (int i = 0; i < NQ; i++) begin
            if (rv_in[i]) begin
                s = int'(stg_in[i*SW +: SW]);
                if (!win || s > ws) begin
                    win = 1; ws = s; wt = tgt_in[i*AW +: AW];
                end
            end
        end
        mask = win ? NS'((1 << ws) - 1) : '0;
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                m_off[d] = 0; m_stall[d] = 0; m_tgt[d] = '0; m_cnt[d] = 0;
                exp_fv = '1;
            end else begin
                exp_fv = mask | NS'(m_off[d] || m_stall[d] > 0);
            end
            stall = rst_n && (m_off[d] || m_stall[d] > 0);
            chk($sformatf("d%0d.flush_vec", d), 32'(o_fv[d]), 32'(exp_fv));
            chk($sformatf("d%0d.redirect_valid", d), 32'(o_rv[d]), 32'(m_off[d]));
            chk($sformatf("d%0d.redirect_target", d), o_rt[d], m_tgt[d]);
            chk($sformatf("d%0d.fetch_stall", d), 32'(o_fs[d]), 32'(stall));
            chk($sformatf("d%0d.flush_count", d), 32'(o_fc[d]), 32'(m_cnt[d]));
            if (rst_n) begin
                if (win) begin
                    m_off[d] = 1; m_tgt[d] = wt; m_stall[d] = 0;
                    if (m_cnt[d] < 65535) m_cnt[d]++;
                end else if (m_off[d] && rdy) begin
                    m_off[d] = 0; m_stall[d] = hold_of[d];
                end else if (m_stall[d] > 0) begin
                    m_stall[d]--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_req();
        rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rdy = 1'b0;
        clear_req();
        for (int d = 0; d < ND; d++) begin
            m_off[d] = 0; m_stall[d] = 0; m_tgt[d] = '0; m_cnt[d] = 0;
        end
        @(posedge clk);
        #1;

        // Reset state.
        chk("rst.flush_vec", 32'(o_fv[1]), 32'h1f);
        chk("rst.redirect_valid", 32'(o_rv[1]), 32'h0);
        chk("rst.fetch_stall", 32'(o_fs[1]), 32'h0);
        chk("rst.flush_count", 32'(o_fc[1]), 32'h0);
        do_reset();

        // Jump from stage 1, ready high, hold 1.
        rdy = 1'b1;
        set_req(SRC_JUMP, 1, 32'h40);
        #1 chk("jump.flush_vec", 32'(o_fv[1]), 32'h01);
        tick(); clear_req();
        #1 chk("jump.rv_c1", 32'(o_rv[1]), 32'h1);
        chk("jump.target", o_rt[1], 32'h40);
        chk("jump.stall_c1", 32'(o_fs[1]), 32'h1);
        tick();
        #1 chk("jump.rv_c2", 32'(o_rv[1]), 32'h0);
        chk("jump.stall_c2", 32'(o_fs[1]), 32'h1);
        tick();
        #1 chk("jump.stall_c3", 32'(o_fs[1]), 32'h0);
        chk("jump.count", 32'(o_fc[1]), 32'h1);
        tick();

        // Branch at 2 vs jump at 1 in one cycle.
        do_reset();
        rdy = 1'b1;
        set_req(SRC_BRANCH, 2, 32'h100);
        set_req(SRC_JUMP, 1, 32'h200);
        #1 chk("pair.flush_vec", 32'(o_fv[1]), 32'h03);
        tick(); clear_req();
        #1 chk("pair.target", o_rt[1], 32'h100);
        chk("pair.count", 32'(o_fc[1]), 32'h1);
        tick(); tick();

        // jr at 2 with ready low for three cycles.
        do_reset();
        rdy = 1'b0;
        set_req(SRC_JR, 2, 32'h80);
        tick(); clear_req();
        for (int k = 0; k < 3; k++) begin
            #1 chk("jr.rv_wait", 32'(o_rv[1]), 32'h1);
            chk("jr.target_wait", o_rt[1], 32'h80);
            chk("jr.fv0_wait", 32'(o_fv[1][0]), 32'h1);
            tick();
        end
        rdy = 1'b1;
        #1 chk("jr.rv_accept", 32'(o_rv[1]), 32'h1);
        chk("jr.target_accept", o_rt[1], 32'h80);
        tick();
        rdy = 1'b0;
        #1 chk("jr.rv_after", 32'(o_rv[1]), 32'h0);
        chk("jr.fv0_hold", 32'(o_fv[1][0]), 32'h1);
        tick(); tick();

        // Exception preempting HOLD, hold 4.
        do_reset();
        rdy = 1'b1;
        set_req(SRC_JUMP, 1, 32'h40);
        tick(); clear_req();
        tick();
        #1 chk("exc.in_hold", 32'(o_fs[2]), 32'h1);
        chk("exc.rv_hold", 32'(o_rv[2]), 32'h0);
        set_req(SRC_EXC, 3, 32'h8000_0180);
        #1 chk("exc.flush_vec", 32'(o_fv[2]), 32'h07);
        tick(); clear_req();
        #1 chk("exc.rv", 32'(o_rv[2]), 32'h1);
        chk("exc.target", o_rt[2], 32'h8000_0180);
        chk("exc.count", 32'(o_fc[2]), 32'h2);
        for (int k = 0; k < 6; k++) tick();

        // New branch in the acceptance cycle.
        do_reset();
        rdy = 1'b1;
        set_req(SRC_JUMP, 1, 32'h40);
        tick(); clear_req();
        set_req(SRC_BRANCH, 2, 32'h300);
        tick(); clear_req();
        #1 chk("same.rv", 32'(o_rv[1]), 32'h1);
        chk("same.target", o_rt[1], 32'h300);
        tick(); tick(); tick();

        // Reset in the middle of REDIRECT.
        do_reset();
        rdy = 1'b0;
        set_req(SRC_BRANCH, 1, 32'h40);
        tick(); clear_req();
        #1 chk("mid.rv_before", 32'(o_rv[1]), 32'h1);
        rst_n = 1'b0;
        #1 chk("mid.rv_reset", 32'(o_rv[1]), 32'h0);
        chk("mid.fv_reset", 32'(o_fv[1]), 32'h1f);
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("mid.rv_release", 32'(o_rv[1]), 32'h0);
        chk("mid.count", 32'(o_fc[1]), 32'h0);
        chk("mid.stall", 32'(o_fs[1]), 32'h0);
        tick();
        #1 chk("mid.rv_later", 32'(o_rv[1]), 32'h0);
        tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            clear_req();
            for (int i = 0; i < NQ; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_req(i, int'($urandom_range(0, NS - 1)), 32'($urandom));
                end
            end
            rdy = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;

        // Counter saturation.
        do_reset();
        for (int c = 0; c < 70000; c++) begin
            clear_req();
            set_req(SRC_JUMP, int'($urandom_range(0, NS - 1)), 32'(c));
            rdy = 1'($urandom_range(0, 1));
            tick();
        end
        clear_req();
        #1 chk("sat.count0", 32'(o_fc[0]), 32'hffff);
        chk("sat.count1", 32'(o_fc[1]), 32'hffff);
        chk("sat.count2", 32'(o_fc[2]), 32'hffff);
        set_req(SRC_EXC, 4, 32'h1234);
        tick(); clear_req();
        #1 chk("sat.hold", 32'(o_fc[1]), 32'hffff);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
